// File: rtl/spi_slave_cfg.sv
// Parametrised SPI slave (word width, CPOL/CPHA, bit order) with TX shadow and RX valid/ready.
// Optional: define SPI_SLV_OVERRUN_EN to drop words that arrive while rx_data is unconsumed.
module spi_slave_cfg #(
  parameter int unsigned    N           = 8,
  parameter int unsigned    CPOL        = 0,
  parameter int unsigned    CPHA        = 0,
  parameter int unsigned    LSB_FIRST   = 0,
  parameter int unsigned    SYNC_STAGES = 2,
  parameter logic [N-1:0]   TX_DEFAULT  = N'('h0A)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         SCK,
  input  logic         CS,
  input  logic         MOSI,
  output logic         MISO,
  input  logic [N-1:0] tx_data,
  input  logic         tx_load,
  output logic         tx_ready,
  output logic [N-1:0] rx_data,
  output logic         rx_valid,
  input  logic         rx_ready,
  output logic         busy,
  output logic         done,
  output logic         overrun
);

  localparam int unsigned CW       = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST   = CW'(N - 1);
  localparam logic        CPOL_L   = 1'(CPOL);
  localparam logic        SAMPLE_RISE = (CPOL == CPHA);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [N-1:0]           rx_shift_q, rx_shift_d;
  logic [N-1:0]           rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   done_q, done_d;
  logic [N-1:0]           tx_shift_q, tx_shift_d;
  logic [N-1:0]           shadow_q, shadow_d;
  logic                   full_q, full_d;
  logic                   miso_q, miso_d;
  logic                   busy_q, busy_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   overrun_q, overrun_d;

  logic sck_s, cs_s, mosi_s;
  logic rise, fall, sample_edge, shift_edge, cs_fall, load_pt;
  logic [N-1:0] rx_word;

  assign sck_s       = sck_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign rise        = sck_s & ~sck_prev_q;
  assign fall        = ~sck_s & sck_prev_q;
  assign sample_edge = SAMPLE_RISE ? rise : fall;
  assign shift_edge  = SAMPLE_RISE ? fall : rise;
  assign cs_fall     = ~cs_s & cs_prev_q;

  // State register, synchronizers and all datapath flops
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      sck_sync_q  <= {SYNC_STAGES{CPOL_L}};
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= '0;
      sck_prev_q  <= CPOL_L;
      cs_prev_q   <= 1'b1;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      tx_shift_q  <= '0;
      shadow_q    <= '0;
      full_q      <= 1'b0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      tx_ready_q  <= 1'b1;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      done_q      <= done_d;
      tx_shift_q  <= tx_shift_d;
      shadow_q    <= shadow_d;
      full_q      <= full_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
      tx_ready_q  <= tx_ready_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    if (LSB_FIRST != 0) rx_word = {mosi_s, rx_shift_q[N-1:1]};
    else                rx_word = {rx_shift_q[N-2:0], mosi_s};
  end

  // Next-state logic: FSM, bit counter, RX assembly, TX load/shift, shadow handshake
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    done_d     = 1'b0;
    tx_shift_d = tx_shift_q;
    shadow_d   = shadow_q;
    full_d     = full_q;
    overrun_d  = overrun_q;
    load_pt    = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (cs_fall) begin
          state_d = ACTIVE;
          load_pt = (CPHA == 0);
        end
      end
      ACTIVE: begin
        if (cs_s) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else begin
          if (sample_edge) begin
            rx_shift_d = rx_word;
            bit_cnt_d  = (bit_cnt_q == LAST) ? '0 : bit_cnt_q + CW'(1);
            if (bit_cnt_q == LAST) begin
              done_d = 1'b1;
`ifdef SPI_SLV_OVERRUN_EN
              if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
              end else begin
                rx_data_d  = rx_word;
                rx_valid_d = 1'b1;
              end
`else
              rx_data_d  = rx_word;
              rx_valid_d = 1'b1;
`endif
            end
          end
          if (shift_edge) begin
            if (bit_cnt_q == '0)     load_pt    = 1'b1;
            else if (LSB_FIRST != 0) tx_shift_d = {1'b0, tx_shift_q[N-1:1]};
            else                     tx_shift_d = {tx_shift_q[N-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_pt) begin
      if (full_q) begin
        tx_shift_d = shadow_q;
        full_d     = 1'b0;
      end else begin
        tx_shift_d = TX_DEFAULT;
      end
    end

    // A load arriving on an empty-shadow load point stays queued for the next word
    if (tx_load && !full_q) begin
      shadow_d = tx_data;
      full_d   = 1'b1;
    end

    busy_d     = (state_d == ACTIVE);
    tx_ready_d = !full_d;
    if (state_d == ACTIVE) miso_d = (LSB_FIRST != 0) ? tx_shift_d[0] : tx_shift_d[N-1];
    else                   miso_d = 1'b0;
  end

  assign MISO     = miso_q;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef SPI_SLV_OVERRUN_EN
  assign overrun  = overrun_q;
`else
  assign overrun  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_cfg.sv
// Directed bench: instance 0 is mode 0 MSB-first, instance 1 is mode 3 LSB-first.
module tb_spi_slave_cfg;
  localparam int unsigned H = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] sck, cs, mosi, tx_load, rx_ready;
  logic [7:0] tx_data;
  logic       miso0, miso1, tx_ready0, tx_ready1, rx_valid0, rx_valid1;
  logic       busy0, busy1, done0, done1, overrun0, overrun1;
  logic [7:0] rx_data0, rx_data1;

  int n_checks = 0;
  int n_err    = 0;
  int dc0 = 0;
  int dc1 = 0;

  spi_slave_cfg #(.N(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0)) u_m0 (
    .clk(clk), .reset(reset), .SCK(sck[0]), .CS(cs[0]), .MOSI(mosi[0]), .MISO(miso0),
    .tx_data(tx_data), .tx_load(tx_load[0]), .tx_ready(tx_ready0), .rx_data(rx_data0),
    .rx_valid(rx_valid0), .rx_ready(rx_ready[0]), .busy(busy0), .done(done0), .overrun(overrun0));

  spi_slave_cfg #(.N(8), .CPOL(1), .CPHA(1), .LSB_FIRST(1)) u_m3 (
    .clk(clk), .reset(reset), .SCK(sck[1]), .CS(cs[1]), .MOSI(mosi[1]), .MISO(miso1),
    .tx_data(tx_data), .tx_load(tx_load[1]), .tx_ready(tx_ready1), .rx_data(rx_data1),
    .rx_valid(rx_valid1), .rx_ready(rx_ready[1]), .busy(busy1), .done(done1), .overrun(overrun1));

  always @(posedge clk) begin
    if (done0) dc0 <= dc0 + 1;
    if (done1) dc1 <= dc1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic miso_of(input int w);
    return (w == 1) ? miso1 : miso0;
  endfunction

  task automatic load_tx(input int w, input logic [7:0] v);
    tx_data = v;
    tx_load[w] = 1'b1;
    wclk(1);
    tx_load[w] = 1'b0;
    wclk(1);
  endtask

  task automatic consume(input int w);
    rx_ready[w] = 1'b1;
    wclk(1);
    rx_ready[w] = 1'b0;
    wclk(1);
  endtask

  task automatic cs_low(input int w);
    cs[w] = 1'b0;
    wclk(2 * H);
  endtask

  task automatic cs_high(input int w);
    wclk(H);
    cs[w] = 1'b1;
    wclk(2 * H);
  endtask

  // Master side: instance 0 is mode 0 MSB-first, instance 1 is mode 3 LSB-first
  task automatic spi_word(input int w, input logic [7:0] mo, input int nbits,
                          output logic [7:0] cap);
    logic pol;
    pol = (w == 1);
    cap = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = (w == 1) ? i : 7 - i;
      if (w == 0) begin
        mosi[w] = mo[b];
        wclk(H);
        cap[b] = miso_of(w);
        sck[w] = ~pol;
        wclk(H);
        sck[w] = pol;
      end else begin
        sck[w] = ~pol;
        mosi[w] = mo[b];
        wclk(H);
        sck[w] = pol;
        cap[b] = miso_of(w);
        wclk(H);
      end
    end
  endtask

  initial begin
    logic [7:0] cap;
    int base;
    reset = 1'b0; sck = 2'b10; cs = 2'b11; mosi = 2'b00;
    tx_load = 2'b00; rx_ready = 2'b00; tx_data = 8'h00;
    wclk(4);
    reset = 1'b1;
    wclk(2);

    check("rst_miso0", miso0, 0);       check("rst_tx_ready0", tx_ready0, 1);
    check("rst_rx_data0", rx_data0, 0); check("rst_rx_valid0", rx_valid0, 0);
    check("rst_busy0", busy0, 0);       check("rst_overrun0", overrun0, 0);
    check("rst_miso1", miso1, 0);       check("rst_tx_ready1", tx_ready1, 1);
    check("rst_done", {done1, done0}, 0);

    // Mode 0: 0xA5 in, 0x3C out; second load while full is ignored
    load_tx(0, 8'h3C);
    check("t1_tx_ready_full", tx_ready0, 0);
    load_tx(0, 8'h99);
    base = dc0;
    cs_low(0);
    check("t1_busy", busy0, 1);
    spi_word(0, 8'hA5, 8, cap);
    cs_high(0);
    check("t1_rx_data", rx_data0, 8'hA5);
    check("t1_rx_valid", rx_valid0, 1);
    check("t1_done_cnt", dc0 - base, 1);
    check("t1_miso_cap", cap, 8'h3C);
    check("t1_tx_ready", tx_ready0, 1);
    check("t1_idle_busy", busy0, 0);
    check("t1_idle_miso", miso0, 0);
    consume(0);
    check("t1_rx_valid_clr", rx_valid0, 0);

    // Mode 3, LSB first
    load_tx(1, 8'h81);
    base = dc1;
    cs_low(1);
    spi_word(1, 8'h0F, 8, cap);
    cs_high(1);
    check("t2_rx_data", rx_data1, 8'h0F);
    check("t2_rx_valid", rx_valid1, 1);
    check("t2_miso_cap", cap, 8'h81);
    check("t2_done_cnt", dc1 - base, 1);
    check("t2_tx_ready", tx_ready1, 1);
    consume(1);

    // Back-to-back words, shadow filled only for the first
    load_tx(0, 8'h5A);
    cs_low(0);
    spi_word(0, 8'h11, 8, cap);
    check("t3_rx_w1", rx_data0, 8'h11);
    check("t3_cap_w1", cap, 8'h5A);
    consume(0);
    spi_word(0, 8'h22, 8, cap);
    check("t3_cap_w2", cap, 8'h0A);
    cs_high(0);
    check("t3_rx_w2", rx_data0, 8'h22);
    check("t3_valid_w2", rx_valid0, 1);
    consume(0);

    // Abort after 5 bits, then a full word
    base = dc0;
    cs_low(0);
    spi_word(0, 8'hFF, 5, cap);
    cs_high(0);
    check("t4_abort_valid", rx_valid0, 0);
    check("t4_abort_done", dc0 - base, 0);
    check("t4_abort_data", rx_data0, 8'h22);
    cs_low(0);
    spi_word(0, 8'hC3, 8, cap);
    cs_high(0);
    check("t4_rx_data", rx_data0, 8'hC3);
    check("t4_rx_valid", rx_valid0, 1);
    consume(0);

    // Two words with rx_ready held low
    base = dc0;
    cs_low(0);
    spi_word(0, 8'h01, 8, cap);
    spi_word(0, 8'h02, 8, cap);
    cs_high(0);
    check("t5_done_cnt", dc0 - base, 2);
    check("t5_rx_valid", rx_valid0, 1);
`ifdef SPI_SLV_OVERRUN_EN
    check("t5_rx_data", rx_data0, 8'h01);
    check("t5_overrun", overrun0, 1);
`else
    check("t5_rx_data", rx_data0, 8'h02);
    check("t5_overrun", overrun0, 0);
`endif

    // Reset mid-word with a loaded shadow, then a clean word
    cs_low(0);
    spi_word(0, 8'hFF, 4, cap);
    load_tx(0, 8'h77);
    check("t6_tx_ready_full", tx_ready0, 0);
    reset = 1'b0; cs[0] = 1'b1; sck[0] = 1'b0; mosi[0] = 1'b0;
    wclk(3);
    reset = 1'b1;
    wclk(2);
    check("t6_rst_rx_data", rx_data0, 0);
    check("t6_rst_rx_valid", rx_valid0, 0);
    check("t6_rst_busy", busy0, 0);
    check("t6_rst_tx_ready", tx_ready0, 1);
    check("t6_rst_overrun", overrun0, 0);
    check("t6_rst_miso", miso0, 0);
    cs_low(0);
    spi_word(0, 8'h66, 8, cap);
    cs_high(0);
    check("t6_rx_data", rx_data0, 8'h66);
    check("t6_cap_default", cap, 8'h0A);
    check("t6_tx_ready", tx_ready0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
